// File: rtl/datapath_sequencer.sv
// datapath_sequencer: two-cycle fetch/execute controller for the 4-register,
// 4-bit datapath. It fetches from a 16-word instruction memory at PC, decodes
// the instruction register into the 13-bit control word, and sequences the PC,
// branches, the memory write strobe and halt.
//
// Build option: define SEQ_ILLEGAL_TRAP_EN to trap opcode E (Error=1, go to
// HALT). When it is undefined, opcode E behaves as NOP and Error stays 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | out of reset, waiting for Start
// FETCH | latch Instr into IR, control word held at zero
// EXEC  | drive decoded control word, update PC at end of cycle
// HALT  | HLT or trap executed, Done high, waiting for Start to restart
module datapath_sequencer (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Start,
  input  logic [15:0] Instr,
  input  logic        Zero,
  output logic [3:0]  PC,
  output logic [12:0] ControlWord,
  output logic [3:0]  ConstantIn,
  output logic        MemWr,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BRZ  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_RSV  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [3:0] FS_A    = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SUB  = 4'b0101;
  localparam logic [3:0] FS_AND  = 4'b1000;
  localparam logic [3:0] FS_OR   = 4'b1001;
  localparam logic [3:0] FS_XOR  = 4'b1010;
  localparam logic [3:0] FS_NOTA = 4'b1011;
  localparam logic [3:0] FS_B    = 4'b1100;

  state_t      state_q;
  logic [3:0]  pc_q, pc_d;
  logic [15:0] ir_q;
  logic        error_q, busy_q, done_q;

  logic [3:0]  op, imm;
  logic [1:0]  dr, sa, sb;
  logic        mb, md, rw, mem_wr, fields_en, trap_op, halt_op;
  logic [3:0]  fs;
  logic        unused_ir_bits;

  assign op  = ir_q[15:12];
  assign dr  = ir_q[11:10];
  assign sa  = ir_q[9:8];
  assign sb  = ir_q[7:6];
  assign imm = ir_q[3:0];
  // IR bits [5:4] carry no meaning in the instruction format.
  assign unused_ir_bits = ^ir_q[5:4];

`ifdef SEQ_ILLEGAL_TRAP_EN
  assign trap_op = (op == OP_RSV);
`else
  assign trap_op = 1'b0;
`endif

  assign halt_op = (op == OP_HLT) || trap_op;

  // Opcode decode into datapath control fields; only driven out during EXEC.
  always_comb begin
    mb        = 1'b0;
    md        = 1'b0;
    rw        = 1'b0;
    fs        = FS_A;
    mem_wr    = 1'b0;
    fields_en = 1'b1;
    case (op)
      OP_NOP:  fields_en = 1'b0;
      OP_MOV:  begin fs = FS_A;    rw = 1'b1; end
      OP_ADD:  begin fs = FS_ADD;  rw = 1'b1; end
      OP_SUB:  begin fs = FS_SUB;  rw = 1'b1; end
      OP_AND:  begin fs = FS_AND;  rw = 1'b1; end
      OP_OR:   begin fs = FS_OR;   rw = 1'b1; end
      OP_XOR:  begin fs = FS_XOR;  rw = 1'b1; end
      OP_NOT:  begin fs = FS_NOTA; rw = 1'b1; end
      OP_ADDI: begin mb = 1'b1; fs = FS_ADD; rw = 1'b1; end
      OP_LDI:  begin mb = 1'b1; fs = FS_B;   rw = 1'b1; end
      OP_LD:   begin md = 1'b1; rw = 1'b1; end
      OP_ST:   mem_wr = 1'b1;
      OP_RSV:  fields_en = 1'b0;
      default: ;
    endcase

    ControlWord = 13'd0;
    ConstantIn  = 4'd0;
    MemWr       = 1'b0;
    if ((state_q == S_EXEC) && fields_en) begin
      ControlWord = {dr, sa, sb, mb, fs, md, rw};
      ConstantIn  = imm;
      MemWr       = mem_wr;
    end
  end

  // Next PC at the end of EXEC: jump, conditional branch on Zero, or increment.
  always_comb begin
    pc_d = pc_q + 4'd1;
    if (op == OP_JMP) begin
      pc_d = imm;
    end else if ((op == OP_BRZ) && Zero) begin
      pc_d = imm;
    end
  end

  // Sequencer FSM with registered PC, IR and status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pc_q    <= 4'd0;
      ir_q    <= 16'd0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q <= S_FETCH;
            pc_q    <= 4'd0;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir_q    <= Instr;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (halt_op) begin
            state_q <= S_HALT;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= trap_op;
          end else begin
            state_q <= S_FETCH;
            pc_q    <= pc_d;
          end
        end
        S_HALT: begin
          if (Start) begin
            state_q <= S_FETCH;
            pc_q    <= 4'd0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign PC    = pc_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Error = error_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed vector table, hand
// sequences for reset/halt/restart/loop/illegal opcode, and random programs
// checked against an instruction-level reference model.
module tb_datapath_sequencer;

  logic        CLK, RST_N, Start, Zero;
  logic [15:0] Instr;
  logic [3:0]  PC, ConstantIn;
  logic [12:0] ControlWord;
  logic        MemWr, Busy, Done, Error;

  logic [15:0] imem [16];
  assign Instr = imem[PC];

`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  datapath_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Instr(Instr), .Zero(Zero),
    .PC(PC), .ControlWord(ControlWord), .ConstantIn(ConstantIn),
    .MemWr(MemWr), .Busy(Busy), .Done(Done), .Error(Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    Start = 1'b0;
    Zero  = 1'b0;
    #3;
    RST_N = 1'b1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
  endtask

  // Reference decode built from the instruction-set table.
  task automatic model_decode(input logic [15:0] w, output logic [12:0] cw,
                              output logic [3:0] ci, output logic mw);
    int op, dr, sa, sb, mb, fs, md, rw;
    op = int'(w[15:12]);
    dr = int'(w[11:10]);
    sa = int'(w[9:8]);
    sb = int'(w[7:6]);
    mb = 0; fs = 0; md = 0; rw = 0;
    mw = (op == 11);
    if (op == 0 || op == 14) begin
      cw = 13'd0;
      ci = 4'd0;
      return;
    end
    if (op >= 1 && op <= 10) rw = 1;
    case (op)
      2:  fs = 2;
      3:  fs = 5;
      4:  fs = 8;
      5:  fs = 9;
      6:  fs = 10;
      7:  fs = 11;
      8:  begin mb = 1; fs = 2; end
      9:  begin mb = 1; fs = 12; end
      10: md = 1;
      default: ;
    endcase
    cw = 13'(dr * 2048 + sa * 512 + sb * 128 + mb * 64 + fs * 4 + md * 2 + rw);
    ci = w[3:0];
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] instr;
    logic        zero;
    logic [12:0] cw;
    logic [3:0]  ci;
    logic        memwr;
    logic [3:0]  next_pc;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [12:0] ecw;
    logic [3:0]  eci, mpc;
    logic        emw, z;
    logic [15:0] w;

    imem[0] = 16'h0; // avoid X on Instr before the first clear
    clear_imem();
    do_reset();

    // Reset state
    chk("rst_cw",    ControlWord, 13'd0);
    chk("rst_ci",    ConstantIn,  4'd0);
    chk("rst_pc",    PC,          4'd0);
    chk("rst_memwr", MemWr,       1'b0);
    chk("rst_busy",  Busy,        1'b0);
    chk("rst_done",  Done,        1'b0);
    chk("rst_error", Error,       1'b0);

    // Directed program walked in execution order
    vecs[0] = '{4'd0,  16'h9405, 1'b0, 13'h0871, 4'h5, 1'b0, 4'd1};  // LDI R1,5
    vecs[1] = '{4'd1,  16'h9803, 1'b0, 13'h1071, 4'h3, 1'b0, 4'd2};  // LDI R2,3
    vecs[2] = '{4'd2,  16'h2D80, 1'b0, 13'h1B09, 4'h0, 1'b0, 4'd3};  // ADD R3,R1,R2
    vecs[3] = '{4'd3,  16'hB240, 1'b0, 13'h0480, 4'h0, 1'b1, 4'd4};  // ST R1->[R2]
    vecs[4] = '{4'd4,  16'hC009, 1'b1, 13'h0000, 4'h9, 1'b0, 4'd9};  // BRZ taken
    vecs[5] = '{4'd9,  16'hC002, 1'b0, 13'h0000, 4'h2, 1'b0, 4'd10}; // BRZ not taken
    vecs[6] = '{4'd10, 16'hD00E, 1'b0, 13'h0000, 4'hE, 1'b0, 4'd14}; // JMP 14
    vecs[7] = '{4'd14, 16'hA200, 1'b0, 13'h0403, 4'h0, 1'b0, 4'd15}; // LD R0,[R2]
    vecs[8] = '{4'd15, 16'h0FFF, 1'b0, 13'h0000, 4'h0, 1'b0, 4'd0};  // NOP, wrap
    clear_imem();
    for (int i = 0; i < 9; i++) imem[vecs[i].addr] = vecs[i].instr;
    step();
    Start = 1'b1; step(); Start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("vec_fetch_pc", PC, vecs[i].addr);
      chk("vec_fetch_cw", ControlWord, 13'd0);
      Zero = vecs[i].zero;
      step();
      chk("vec_cw",    ControlWord, vecs[i].cw);
      chk("vec_ci",    ConstantIn,  vecs[i].ci);
      chk("vec_memwr", MemWr,       vecs[i].memwr);
      step();
      chk("vec_next_pc", PC, vecs[i].next_pc);
      chk("vec_memwr_off", MemWr, 1'b0);
    end

    // Asynchronous reset in the middle of an ADD's EXEC cycle
    clear_imem();
    imem[0] = 16'h2D80;
    do_reset(); step();
    Start = 1'b1; step(); Start = 1'b0;
    step();
    chk("midexec_rw_before", ControlWord[0], 1'b1);
    #1 RST_N = 1'b0;
    #1;
    chk("midexec_cw",   ControlWord, 13'd0);
    chk("midexec_busy", Busy,        1'b0);
    chk("midexec_pc",   PC,          4'd0);
    #1 RST_N = 1'b1;
    step();
    chk("midexec_idle", Busy, 1'b0);

    // LDI/LDI/ADD/HLT: Done after 8 edges, then held Start restarts in 1 cycle
    clear_imem();
    imem[0] = 16'h9405; imem[1] = 16'h9803; imem[2] = 16'h2D80; imem[3] = 16'hF000;
    do_reset(); step();
    Start = 1'b1; step(); Start = 1'b0;
    repeat (7) step();
    chk("hlt_done_early", Done, 1'b0);
    step();
    chk("hlt_done", Done, 1'b1);
    chk("hlt_busy", Busy, 1'b0);
    chk("hlt_pc",   PC,   4'd3);
    step();
    chk("hlt_stays", Done, 1'b1);
    Start = 1'b1; step(); Start = 1'b0;
    chk("restart_busy", Busy, 1'b1);
    chk("restart_done", Done, 1'b0);
    chk("restart_pc",   PC,   4'd0);

    // JMP 0 self-loop ignores Start toggling
    clear_imem();
    imem[0] = 16'hD000; imem[1] = 16'hF000;
    do_reset(); step();
    Start = 1'b1; step(); Start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      Start = ~Start;
      step();
    end
    Start = 1'b0;
    chk("loop_pc",   PC,   4'd0);
    chk("loop_busy", Busy, 1'b1);
    chk("loop_done", Done, 1'b0);

    // Reserved opcode E
    clear_imem();
    imem[0] = 16'hE3C7; imem[1] = 16'hF000;
    do_reset(); step();
    Start = 1'b1; step(); Start = 1'b0;
    step();
    chk("ill_cw", ControlWord, 13'd0);
    chk("ill_ci", ConstantIn,  4'd0);
    step();
    chk("ill_error", Error, TRAP);
    chk("ill_done",  Done,  TRAP);
    chk("ill_pc",    PC,    TRAP ? 4'd0 : 4'd1);
    if (TRAP) begin
      Start = 1'b1; step(); Start = 1'b0;
      chk("ill_restart_error", Error, 1'b0);
    end

    // Random programs against the instruction-level model
    for (int prog = 0; prog < 4; prog++) begin
      for (int i = 0; i < 16; i++) imem[i] = 16'($urandom);
      do_reset(); step();
      Start = 1'b1; step(); Start = 1'b0;
      mpc = 4'd0;
      for (int n = 0; n < 60; n++) begin
        chk("rnd_fetch_pc", PC,   mpc);
        chk("rnd_busy",     Busy, 1'b1);
        w = imem[mpc];
        z = 1'($urandom_range(0, 1));
        Zero = z;
        step();
        model_decode(w, ecw, eci, emw);
        chk("rnd_cw",    ControlWord, ecw);
        chk("rnd_ci",    ConstantIn,  eci);
        chk("rnd_memwr", MemWr,       emw);
        step();
        if (w[15:12] == 4'hF || (TRAP && w[15:12] == 4'hE)) begin
          chk("rnd_done",     Done,  1'b1);
          chk("rnd_error",    Error, (w[15:12] == 4'hE));
          chk("rnd_halt_pc",  PC,    mpc);
          Start = 1'b1; step(); Start = 1'b0;
          mpc = 4'd0;
        end else if (w[15:12] == 4'hD) begin
          mpc = w[3:0];
        end else if (w[15:12] == 4'hC && z) begin
          mpc = w[3:0];
        end else begin
          mpc = 4'((int'(mpc) + 1) % 16);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
